// File: rtl/cipher_pkg.sv
// ============================================================================
// cipher_pkg : shared Caesar-style cipher constants, types and letter arithmetic
// Rev 1.0
// ============================================================================
`default_nettype none

package cipher_pkg;

  localparam int ASCII_A     = 65;
  localparam int ALPHA_LEN   = 26;
  localparam int CASE_OFFSET = 32;

  typedef logic [7:0] char_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic is_upper(char_t c);
    return (c >= char_t'(ASCII_A)) && (c <= char_t'(ASCII_A + ALPHA_LEN - 1));
  endfunction

  function automatic logic [4:0] key_mod26(logic [7:0] v);
    return 5'(v % 8'(ALPHA_LEN));
  endfunction

  // Inverse letter shift; the encrypt path uses the same operand widths.
  function automatic char_t shift_back(char_t c, logic [4:0] k);
    logic [5:0] d;
    logic [5:0] p;
    d = 6'(c - char_t'(ASCII_A));
    p = d + 6'(ALPHA_LEN) - {1'b0, k};
    if (p >= 6'(ALPHA_LEN)) p = p - 6'(ALPHA_LEN);
    return char_t'(p) + char_t'(ASCII_A);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cipher_key_regfile.sv
// ============================================================================
// cipher_key_regfile : KEY_LEN x 5-bit shift entries, one write, one async read
// Rev 1.0
// ============================================================================
`default_nettype none

module cipher_key_regfile import cipher_pkg::*; #(
  parameter int KEY_LEN = 4,
  parameter int KEY_AW  = $clog2(KEY_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic              busy_i,
  input  logic [KEY_AW-1:0] waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic [KEY_AW-1:0] raddr_i,
  output logic [4:0]        rdata_o
);

  logic [4:0] key_q [KEY_LEN];

  // Writes are locked out whenever a frame could be reading the table.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < KEY_LEN; i++) key_q[i] <= '0;
    end else if (we_i && !busy_i) begin
      key_q[waddr_i] <= key_mod26(wdata_i);
    end
  end

  assign rdata_o = key_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/stream_decrypt_case_restore.sv
// ============================================================================
// stream_decrypt_case_restore : streaming keyed-shift decrypt with case restore
// Rev 1.0
// ============================================================================
`default_nettype none

module stream_decrypt_case_restore import cipher_pkg::*; #(
  parameter int MSG_LEN = 13,
  parameter int KEY_LEN = 4,
  parameter int KEY_AW  = $clog2(KEY_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_we,
  input  logic [KEY_AW-1:0] key_addr,
  input  logic [7:0]        key_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  input  logic              s_upper,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [7:0]        m_data,
  output logic              m_last,
  output logic              frame_err,
  output logic              busy
);

  localparam int CW = $clog2(MSG_LEN);
  localparam logic [CW-1:0]     LAST_CNT = CW'(MSG_LEN - 1);
  localparam logic [KEY_AW-1:0] LAST_KEY = KEY_AW'(KEY_LEN - 1);

  state_t            state_q;
  logic [CW-1:0]     cnt_q, cnt_cur, cnt_d;
  logic [KEY_AW-1:0] kidx_q, kidx_cur, kidx_d;
  logic              m_valid_q, m_last_q, m_last_d, frame_err_q, frame_err_d;
  char_t             m_data_q, m_data_d;
  logic              accept, start, letter, at_len;
  logic [4:0]        key_cur;

  assign s_ready = !m_valid_q || m_ready;
  assign accept  = s_valid && s_ready;
  assign start   = (state_q == ST_IDLE);
  assign busy    = (state_q == ST_RUN) || m_valid_q;

  // The first beat of a frame sees count and key index as zero.
  assign cnt_cur  = start ? '0 : cnt_q;
  assign kidx_cur = start ? '0 : kidx_q;
  assign letter   = is_upper(s_data);
  assign at_len   = (cnt_cur == LAST_CNT);

  cipher_key_regfile #(.KEY_LEN(KEY_LEN), .KEY_AW(KEY_AW)) u_key (
    .clk     (clk),
    .rst     (rst),
    .we_i    (key_we),
    .busy_i  (busy || accept),
    .waddr_i (key_addr),
    .wdata_i (key_data),
    .raddr_i (kidx_cur),
    .rdata_o (key_cur)
  );

  always_comb begin
    m_data_d = s_data;
    if (letter) begin
      m_data_d = shift_back(s_data, key_cur);
      if (!s_upper) m_data_d = m_data_d + char_t'(CASE_OFFSET);
    end
  end

  assign m_last_d    = s_last || at_len;
  assign cnt_d       = cnt_cur + 1'b1;
  assign kidx_d      = !letter ? kidx_cur : (kidx_cur == LAST_KEY) ? '0 : kidx_cur + 1'b1;
  assign frame_err_d = (start ? 1'b0 : frame_err_q) | (m_last_d && (s_last != at_len));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      kidx_q      <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else if (accept) begin
      m_valid_q   <= 1'b1;
      m_data_q    <= m_data_d;
      m_last_q    <= m_last_d;
      cnt_q       <= cnt_d;
      kidx_q      <= kidx_d;
      frame_err_q <= frame_err_d;
      state_q     <= m_last_d ? ST_IDLE : ST_RUN;
    end else if (m_ready) begin
      m_valid_q   <= 1'b0;
    end
  end

  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_last    = m_last_q;
  assign frame_err = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_stream_decrypt_case_restore.sv
// ============================================================================
// tb_stream_decrypt_case_restore : directed self-checking bench
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_stream_decrypt_case_restore;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_we;
  logic [1:0] key_addr;
  logic [7:0] key_data;
  logic       s_valid, s_ready, s_upper, s_last;
  logic [7:0] s_data;
  logic       m_valid, m_ready, m_last, frame_err, busy;
  logic [7:0] m_data;

  int checks   = 0;
  int failures = 0;

  logic       cap_en = 1'b0;
  logic [7:0] cap[$];

  stream_decrypt_case_restore #(.MSG_LEN(13), .KEY_LEN(4), .KEY_AW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_we    (key_we),
    .key_addr  (key_addr),
    .key_data  (key_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_upper   (s_upper),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (cap_en && m_valid && m_ready) cap.push_back(m_data);

  initial begin
    #100000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] d, input logic up, input logic last);
    s_valid = 1'b1; s_data = d; s_upper = up; s_last = last;
  endtask

  task automatic idle_in();
    s_valid = 1'b0; s_data = 8'h00; s_upper = 1'b0; s_last = 1'b0;
  endtask

  task automatic write_key(input logic [1:0] a, input logic [7:0] v);
    step();
    key_we = 1'b1; key_addr = a; key_data = v;
    step();
    key_we = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    idle_in();
    @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s idle_timeout busy=%b exp=0", tag, busy);
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    @(negedge clk);
    checks++; if (m_valid !== 1'b0)   begin failures++; $display("FAIL rst_m_valid got=%b exp=0", m_valid); end
    checks++; if (m_data !== 8'h00)   begin failures++; $display("FAIL rst_m_data got=%h exp=00", m_data); end
    checks++; if (m_last !== 1'b0)    begin failures++; $display("FAIL rst_m_last got=%b exp=0", m_last); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL rst_frame_err got=%b exp=0", frame_err); end
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (s_ready !== 1'b1)   begin failures++; $display("FAIL rst_s_ready got=%b exp=1", s_ready); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_cyber();
    logic [7:0] din [5];
    logic [7:0] exp [5];
    logic       up  [5];
    din = '{"F", "B", "E", "H", "U"};
    up  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    exp = '{"C", "y", "b", "e", "r"};
    for (int i = 0; i < 4; i++) write_key(2'(i), 8'd3);
    for (int k = 0; k <= 5; k++) begin
      step();
      if (k < 5) drive(din[k], up[k], k == 4); else idle_in();
      @(negedge clk);
      if (k == 0) begin
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL cyber_latency m_valid=%b exp=0", m_valid); end
      end else begin
        checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL cyber_valid[%0d] got=%b exp=1", k-1, m_valid); end
        checks++; if (m_data !== exp[k-1]) begin failures++; $display("FAIL cyber_data[%0d] got=%h exp=%h", k-1, m_data, exp[k-1]); end
        checks++; if (m_last !== (k == 5)) begin failures++; $display("FAIL cyber_last[%0d] got=%b exp=%b", k-1, m_last, k == 5); end
      end
    end
    checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL cyber_frame_err got=%b exp=1", frame_err); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL cyber_busy_drain got=%b exp=1", busy); end
    wait_idle("cyber");
    checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL cyber_err_sticky got=%b exp=1", frame_err); end
  endtask

  task automatic test_wrap_space();
    logic [7:0] din [3];
    logic [7:0] exp [3];
    din = '{"B", " ", "B"};
    exp = '{"A", " ", "Z"};
    write_key(2'd0, 8'd1);
    write_key(2'd1, 8'd2);
    write_key(2'd2, 8'd0);
    write_key(2'd3, 8'd0);
    for (int k = 0; k <= 3; k++) begin
      step();
      if (k < 3) drive(din[k], 1'b1, k == 2); else idle_in();
      @(negedge clk);
      if (k > 0) begin
        checks++; if (m_data !== exp[k-1]) begin failures++; $display("FAIL wrap_data[%0d] got=%h exp=%h", k-1, m_data, exp[k-1]); end
      end
    end
    wait_idle("wrap");
  endtask

  task automatic test_full_frame();
    logic [7:0] din [13];
    logic [7:0] exp [13];
    logic       up  [13];
    din = '{"C","Y","B","E","R","S","E","C","U","R","I","T","Y"};
    exp = '{"C","y","b","e","R","S","e","C","U","R","I","T","y"};
    up  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,1'b0};
    for (int i = 0; i < 4; i++) write_key(2'(i), 8'd0);
    for (int k = 0; k <= 13; k++) begin
      step();
      if (k < 13) drive(din[k], up[k], k == 12); else idle_in();
      @(negedge clk);
      if (k > 0) begin
        checks++; if (m_data !== exp[k-1]) begin failures++; $display("FAIL full_data[%0d] got=%h exp=%h", k-1, m_data, exp[k-1]); end
        checks++; if (m_last !== (k == 13)) begin failures++; $display("FAIL full_last[%0d] got=%b exp=%b", k-1, m_last, k == 13); end
      end
    end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL full_frame_err got=%b exp=0", frame_err); end
    wait_idle("full");
  endtask

  task automatic test_missing_last();
    for (int k = 0; k <= 13; k++) begin
      step();
      if (k < 13) drive(".", 1'b0, 1'b0); else idle_in();
      @(negedge clk);
      if (k > 0) begin
        checks++; if (m_last !== (k == 13)) begin failures++; $display("FAIL nolast_last[%0d] got=%b exp=%b", k-1, m_last, k == 13); end
      end
    end
    checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL nolast_frame_err got=%b exp=1", frame_err); end
    wait_idle("nolast");
  endtask

  task automatic test_backpressure();
    logic [7:0] exp [6];
    exp = '{"A", "B", "C", "D", "E", "F"};
    cap.delete();
    cap_en = 1'b1;
    step(); drive("A", 1'b1, 1'b0);
    step(); drive("B", 1'b1, 1'b0);
    step(); drive("C", 1'b1, 1'b0);
    step(); m_ready = 1'b0; drive("D", 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL bp_s_ready[%0d] got=%b exp=0", i, s_ready); end
      checks++; if (m_valid !== 1'b1 || m_data !== "C" || m_last !== 1'b0) begin
        failures++; $display("FAIL bp_hold[%0d] got=%b/%h/%b exp=1/43/0", i, m_valid, m_data, m_last);
      end
      step();
    end
    m_ready = 1'b1;
    step(); drive("E", 1'b1, 1'b0);
    step(); drive("F", 1'b1, 1'b1);
    step(); idle_in();
    wait_idle("bp");
    cap_en = 1'b0;
    checks++; if (cap.size() !== 6) begin failures++; $display("FAIL bp_count got=%0d exp=6", cap.size()); end
    for (int i = 0; i < 6 && i < cap.size(); i++) begin
      checks++; if (cap[i] !== exp[i]) begin failures++; $display("FAIL bp_data[%0d] got=%h exp=%h", i, cap[i], exp[i]); end
    end
  endtask

  task automatic test_key_lock();
    step(); drive("H", 1'b1, 1'b0); key_we = 1'b1; key_addr = 2'd0; key_data = 8'd7;
    step(); drive("B", 1'b1, 1'b1); key_addr = 2'd1; key_data = 8'd5;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL lock_busy got=%b exp=1", busy); end
    step(); key_we = 1'b0; idle_in();
    wait_idle("lock_a");
    step(); drive("H", 1'b1, 1'b0);
    step(); drive("B", 1'b1, 1'b1);
    @(negedge clk);
    checks++; if (m_data !== "H") begin failures++; $display("FAIL lock_key0 got=%h exp=48", m_data); end
    step(); idle_in();
    @(negedge clk);
    checks++; if (m_data !== "B") begin failures++; $display("FAIL lock_key1 got=%h exp=42", m_data); end
    wait_idle("lock_b");
    write_key(2'd1, 8'd30);
    step(); drive("H", 1'b1, 1'b0);
    step(); drive("F", 1'b1, 1'b1);
    @(negedge clk);
    checks++; if (m_data !== "H") begin failures++; $display("FAIL newkey_b0 got=%h exp=48", m_data); end
    step(); idle_in();
    @(negedge clk);
    checks++; if (m_data !== "B" || m_last !== 1'b1) begin
      failures++; $display("FAIL newkey_b1 got=%h/%b exp=42/1", m_data, m_last);
    end
    wait_idle("lock_c");
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] exp;
    step(); drive("A", 1'b1, 1'b0);
    step(); drive("A", 1'b1, 1'b0);
    step(); drive(" ", 1'b1, 1'b0);
    step(); drive("A", 1'b1, 1'b0);
    step(); rst = 1'b1; drive("A", 1'b1, 1'b0);
    step(); rst = 1'b0; idle_in();
    @(negedge clk);
    checks++; if (m_valid !== 1'b0 || m_data !== 8'h00 || m_last !== 1'b0) begin
      failures++; $display("FAIL midrst_out got=%b/%h/%b exp=0/00/0", m_valid, m_data, m_last);
    end
    checks++; if (busy !== 1'b0 || frame_err !== 1'b0) begin
      failures++; $display("FAIL midrst_busy_err got=%b/%b exp=0/0", busy, frame_err);
    end
    write_key(2'd0, 8'd2);
    for (int k = 0; k <= 13; k++) begin
      step();
      if (k == 0) drive("C", 1'b1, 1'b0);
      else if (k == 1) drive("F", 1'b1, 1'b0);
      else if (k < 13) drive(".", 1'b1, k == 12);
      else idle_in();
      @(negedge clk);
      if (k > 0) begin
        exp = (k == 1) ? 8'h41 : (k == 2) ? 8'h46 : 8'h2E;
        checks++; if (m_data !== exp) begin failures++; $display("FAIL midrst_data[%0d] got=%h exp=%h", k-1, m_data, exp); end
        checks++; if (m_last !== (k == 13)) begin failures++; $display("FAIL midrst_last[%0d] got=%b exp=%b", k-1, m_last, k == 13); end
      end
    end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL midrst_frame_err got=%b exp=0", frame_err); end
    wait_idle("midrst");
  endtask

  initial begin
    rst = 1'b1; key_we = 1'b0; key_addr = 2'd0; key_data = 8'd0; m_ready = 1'b1;
    idle_in();
    test_reset();
    test_cyber();
    test_wrap_space();
    test_full_frame();
    test_missing_last();
    test_backpressure();
    test_key_lock();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
